// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: mispredict detection, BTB write-back,
// 2-bit direction table and branch statistics.
module branch_resolve_unit #(
  parameter  int BTB_ENTRIES = 8,
  parameter  int BHT_ENTRIES = 64,
  parameter  int CNT_W       = 32,
  localparam int BI_W        = $clog2(BTB_ENTRIES),
  localparam int BH_W        = $clog2(BHT_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      PC_IF,
  output logic             bht_taken_IF,
  input  logic             bubbleE,
  input  logic             br_valid_EX,
  input  logic             br_taken_EX,
  input  logic [31:0]      br_target_EX,
  input  logic [31:0]      PC_EX,
  input  logic             pred_hit_EX,
  input  logic             pred_taken_EX,
  input  logic [31:0]      pred_target_EX,
  input  logic [BI_W-1:0]  pred_index_EX,
  output logic             flush_req,
  output logic [31:0]      PC_redirect,
  output logic             btb_wr_en,
  output logic [BI_W-1:0]  btb_wr_index,
  output logic [31:0]      btb_wr_tag,
  output logic [31:0]      btb_wr_target,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic            res;
  logic            taken_miss;
  logic            nt_miss;
  logic [BH_W-1:0] rd_idx;
  logic [BH_W-1:0] wr_idx;
  logic [1:0]      bht [BHT_ENTRIES];
  logic [BI_W-1:0] alloc_ptr;
  logic            unused_bits;

  assign res    = br_valid_EX & ~bubbleE;
  assign rd_idx = PC_IF[BH_W+1:2];
  assign wr_idx = PC_EX[BH_W+1:2];

  assign unused_bits = ^{PC_IF[31:BH_W+2], PC_IF[1:0]};

  // A taken branch is wrong if we fell through or jumped elsewhere.
  assign taken_miss = br_taken_EX
                    & (~pred_taken_EX
                    | (pred_target_EX != br_target_EX));
  assign nt_miss    = ~br_taken_EX & pred_taken_EX;

  assign flush_req  = rst & res & (taken_miss | nt_miss);

  always_comb begin
    PC_redirect = '0;
    unique case (1'b1)
      flush_req & br_taken_EX:  PC_redirect = br_target_EX;
      flush_req & ~br_taken_EX: PC_redirect = PC_EX + 32'd4;
      default:                  PC_redirect = '0;
    endcase
  end

  // Old value on same-index read/write: no bypass.
  assign bht_taken_IF = bht[rd_idx][1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (res) begin
      if (br_taken_EX && bht[wr_idx] != 2'b11) begin
        bht[wr_idx] <= bht[wr_idx] + 2'b01;
      end else if (!br_taken_EX && bht[wr_idx] != 2'b00) begin
        bht[wr_idx] <= bht[wr_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btb_wr_en     <= 1'b0;
      btb_wr_index  <= '0;
      btb_wr_tag    <= '0;
      btb_wr_target <= '0;
      alloc_ptr     <= '0;
    end else begin
      btb_wr_en <= res & br_taken_EX;
      if (res && br_taken_EX) begin
        btb_wr_tag    <= PC_EX;
        btb_wr_target <= br_target_EX;
        if (pred_hit_EX) begin
          btb_wr_index <= pred_index_EX;
        end else begin
          btb_wr_index <= alloc_ptr;
          alloc_ptr    <= alloc_ptr + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res && branch_cnt != '1) begin
        branch_cnt <= branch_cnt + 1'b1;
      end
      if (flush_req && mispred_cnt != '1) begin
        mispred_cnt <= mispred_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against
// a behavioural model of branch resolution.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] PC_IF;
  logic        bht_taken_IF;
  logic        bubbleE;
  logic        br_valid_EX;
  logic        br_taken_EX;
  logic [31:0] br_target_EX;
  logic [31:0] PC_EX;
  logic        pred_hit_EX;
  logic        pred_taken_EX;
  logic [31:0] pred_target_EX;
  logic [2:0]  pred_index_EX;
  logic        flush_req;
  logic [31:0] PC_redirect;
  logic        btb_wr_en;
  logic [2:0]  btb_wr_index;
  logic [31:0] btb_wr_tag;
  logic [31:0] btb_wr_target;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int checks = 0;
  int errors = 0;

  int          m_bht [64];
  int          m_alloc;
  longint      m_branches;
  longint      m_mispred;
  logic        m_wr_en;
  int          m_wr_idx;
  logic [31:0] m_wr_tag;
  logic [31:0] m_wr_tgt;

  branch_resolve_unit dut (
    .clk(clk), .rst(rst), .PC_IF(PC_IF),
    .bht_taken_IF(bht_taken_IF), .bubbleE(bubbleE),
    .br_valid_EX(br_valid_EX), .br_taken_EX(br_taken_EX),
    .br_target_EX(br_target_EX), .PC_EX(PC_EX),
    .pred_hit_EX(pred_hit_EX), .pred_taken_EX(pred_taken_EX),
    .pred_target_EX(pred_target_EX),
    .pred_index_EX(pred_index_EX), .flush_req(flush_req),
    .PC_redirect(PC_redirect), .btb_wr_en(btb_wr_en),
    .btb_wr_index(btb_wr_index), .btb_wr_tag(btb_wr_tag),
    .btb_wr_target(btb_wr_target), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bidx(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_bht[i] = 1;
    m_alloc = 0;
    m_branches = 0;
    m_mispred = 0;
    m_wr_en = 1'b0;
    m_wr_idx = 0;
    m_wr_tag = '0;
    m_wr_tgt = '0;
  endtask

  // Expected redirect: 0 when no flush.
  task automatic model_flush(output logic f, output logic [31:0] r);
    f = 1'b0;
    r = '0;
    if (br_valid_EX && !bubbleE) begin
      if (br_taken_EX &&
          (!pred_taken_EX || pred_target_EX != br_target_EX)) begin
        f = 1'b1;
        r = br_target_EX;
      end else if (!br_taken_EX && pred_taken_EX) begin
        f = 1'b1;
        r = PC_EX + 32'd4;
      end
    end
  endtask

  task automatic step(input logic v, input logic bub,
                      input logic tk, input logic [31:0] tgt,
                      input logic [31:0] pc, input logic hit,
                      input logic ptk, input logic [31:0] ptgt,
                      input logic [2:0] pidx, input logic [31:0] pcif);
    logic        ef;
    logic [31:0] er;
    int          k;
    br_valid_EX    = v;
    bubbleE        = bub;
    br_taken_EX    = tk;
    br_target_EX   = tgt;
    PC_EX          = pc;
    pred_hit_EX    = hit;
    pred_taken_EX  = ptk;
    pred_target_EX = ptgt;
    pred_index_EX  = pidx;
    PC_IF          = pcif;
    #1;
    model_flush(ef, er);
    chk("flush_req", 32'(flush_req), 32'(ef));
    chk("PC_redirect", PC_redirect, er);
    chk("bht_taken_IF", 32'(bht_taken_IF),
        32'(m_bht[bidx(pcif)] >= 2));
    @(posedge clk);
    m_wr_en = 1'b0;
    if (v && !bub) begin
      m_branches++;
      if (ef) m_mispred++;
      k = bidx(pc);
      if (tk) begin
        if (m_bht[k] < 3) m_bht[k]++;
        m_wr_en  = 1'b1;
        m_wr_tag = pc;
        m_wr_tgt = tgt;
        if (hit) m_wr_idx = int'(pidx);
        else begin
          m_wr_idx = m_alloc;
          m_alloc  = (m_alloc + 1) % 8;
        end
      end else if (m_bht[k] > 0) m_bht[k]--;
    end
    #1;
    chk("btb_wr_en", 32'(btb_wr_en), 32'(m_wr_en));
    if (m_wr_en) begin
      chk("btb_wr_index", 32'(btb_wr_index), 32'(m_wr_idx));
      chk("btb_wr_tag", btb_wr_tag, m_wr_tag);
      chk("btb_wr_target", btb_wr_target, m_wr_tgt);
    end
    chk("branch_cnt", branch_cnt, 32'(m_branches));
    chk("mispred_cnt", mispred_cnt, 32'(m_mispred));
  endtask

  task automatic check_reset_outputs();
    chk("rst_flush", 32'(flush_req), 32'd0);
    chk("rst_redirect", PC_redirect, 32'd0);
    chk("rst_wr_en", 32'(btb_wr_en), 32'd0);
    chk("rst_wr_index", 32'(btb_wr_index), 32'd0);
    chk("rst_wr_tag", btb_wr_tag, 32'd0);
    chk("rst_wr_target", btb_wr_target, 32'd0);
    chk("rst_branch_cnt", branch_cnt, 32'd0);
    chk("rst_mispred_cnt", mispred_cnt, 32'd0);
  endtask

  initial begin
    logic [31:0] t;
    rst = 1'b0;
    PC_IF = 32'h10;
    bubbleE = 1'b0;
    br_valid_EX = 1'b0;
    br_taken_EX = 1'b0;
    br_target_EX = '0;
    PC_EX = '0;
    pred_hit_EX = 1'b0;
    pred_taken_EX = 1'b0;
    pred_target_EX = '0;
    pred_index_EX = '0;
    model_reset();
    #3;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("bht_after_reset", 32'(bht_taken_IF), 32'd0);

    // Taken miss allocates at 0 and redirects to target.
    step(1, 0, 1, 32'h80, 32'h20, 0, 0, 32'h0, 3'd5, 32'h10);
    chk("miss_wr_index0", 32'(btb_wr_index), 32'd0);
    chk("miss_wr_tag", btb_wr_tag, 32'h20);
    chk("mispred_one", mispred_cnt, 32'd1);
    // Predicted taken, actually not taken.
    step(1, 0, 0, 32'h80, 32'h20, 1, 1, 32'h80, 3'd0, 32'h20);
    chk("nt_no_write", 32'(btb_wr_en), 32'd0);
    step(1, 0, 1, 32'h80, 32'h20, 1, 1, 32'h80, 3'd0, 32'h20);
    step(1, 0, 1, 32'h80, 32'h20, 1, 1, 32'h80, 3'd0, 32'h20);
    step(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 3'd0, 32'h20);
    chk("bht8_taken", 32'(bht_taken_IF), 32'd1);
    // Not-taken at the top of the address space wraps to 0.
    step(1, 0, 0, 32'h0, 32'hFFFF_FFFC, 1, 1, 32'h40, 3'd2, 32'h0);
    chk("redirect_wrap", PC_redirect, 32'd0);
    // Stalled branch must not resolve.
    step(1, 1, 1, 32'h90, 32'h44, 0, 0, 32'h0, 3'd0, 32'h44);
    // Reset right after a resolve discards the pending write.
    step(1, 0, 1, 32'h70, 32'h30, 0, 0, 32'h0, 3'd0, 32'h30);
    chk("pre_reset_wr_en", 32'(btb_wr_en), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    br_valid_EX = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // Nine misses: the ninth allocation wraps back to 0.
    for (int i = 0; i < 9; i++) begin
      step(1, 0, 1, 32'h100 + 32'(i), 32'h200 + 32'(4 * i),
           0, 0, 32'h0, 3'd0, 32'h200);
    end
    chk("alloc_wrap_index0", 32'(btb_wr_index), 32'd0);
    // Four taken on one entry saturates the counter.
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 32'h300, 32'h50, 1, 1, 32'h300, 3'd4, 32'h50);
    end
    chk("sat_model", 32'(m_bht[bidx(32'h50)]), 32'd3);

    for (int i = 0; i < 400; i++) begin
      t = $urandom;
      step(($urandom % 4) != 0, ($urandom % 5) == 0,
           $urandom % 2, t, ($urandom % 128) * 4,
           $urandom % 2, $urandom % 2,
           (($urandom % 2) != 0) ? t : $urandom,
           3'($urandom % 8), ($urandom % 128) * 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
